alu_shift_unit: RTL and testbench

ALU_SHIFT_UNIT -- requirements
Module: alu_shift_unit

---
 rtl/alu_shift_unit_pkg.sv | 30 +++
 rtl/alu_barrel_shifter.sv | 44 ++++
 rtl/alu_shift_unit.sv | 61 ++++++
 tb/tb_alu_shift_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_unit_pkg.sv
// ============================================================================
// Module   : alu_shift_unit_pkg
// Purpose  : Shared encodings and widths for the ALU / barrel-shifter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_shift_unit_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [2:0] {
    OP_PASS  = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_SHIFT = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

endpackage

`default_nettype wire

// File: rtl/alu_barrel_shifter.sv
// ============================================================================
// Module   : alu_barrel_shifter
// Purpose  : Combinational 16-bit barrel shifter (LSL/LSR/ASR/ROR).
//            Rotate logic exists only when ALU_SHIFT_ROR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_barrel_shifter
  import alu_shift_unit_pkg::*;
(
  input  logic [1:0]         shift_type,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out
);

`ifdef ALU_SHIFT_ROR_EN
  localparam logic [SHAMT_W:0] c_ROR_SPAN = (SHAMT_W+1)'(DATA_W);

  logic [DATA_W-1:0] w_ror;

  // A left shift by the full width yields zero, so amount 0 falls out naturally.
  assign w_ror = (data_in >> amount) | (data_in << (c_ROR_SPAN - {1'b0, amount}));
`endif

  always_comb begin
    data_out = data_in;
    case (shift_type)
      SH_LSL:  data_out = data_in << amount;
      SH_LSR:  data_out = data_in >> amount;
      SH_ASR:  data_out = $signed(data_in) >>> amount;
`ifdef ALU_SHIFT_ROR_EN
      SH_ROR:  data_out = w_ror;
`else
      SH_ROR:  data_out = data_in;
`endif
      default: data_out = data_in;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_shift_unit.sv
// ============================================================================
// Module   : alu_shift_unit
// Purpose  : Combinational ALU with barrel shifter and a registered zero flag.
//            Optional macro: ALU_SHIFT_ROR_EN enables rotate-right.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_unit
  import alu_shift_unit_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [2:0]        op,
  input  logic [1:0]        shift_type,
  input  logic              f_en,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              f_flag
);

  logic [DATA_W-1:0] w_shift_out;
  logic              r_f_flag;

  alu_barrel_shifter u_shifter (
    .shift_type (shift_type),
    .amount     (bus_in[SHAMT_W-1:0]),
    .data_in    (a_in),
    .data_out   (w_shift_out)
  );

  // Reserved opcodes behave as PASS.
  always_comb begin
    result = bus_in;
    case (op)
      OP_PASS:  result = bus_in;
      OP_ADD:   result = a_in + bus_in;
      OP_SUB:   result = a_in - bus_in;
      OP_AND:   result = a_in & bus_in;
      OP_SHIFT: result = w_shift_out;
      default:  result = bus_in;
    endcase
  end

  assign zero = (result == '0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_f_flag <= 1'b0;
    end else if (f_en) begin
      r_f_flag <= zero;
    end
  end

  assign f_flag = r_f_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_unit.sv
// ============================================================================
// Module   : tb_alu_shift_unit
// Purpose  : Self-checking bench for alu_shift_unit (honours ALU_SHIFT_ROR_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_unit;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] bus_in;
  logic [15:0] a_in;
  logic [2:0]  op;
  logic [1:0]  shift_type;
  logic        f_en;
  logic [15:0] result;
  logic        zero;
  logic        f_flag;

  int   total = 0;
  int   bad   = 0;
  logic exp_flag;

  alu_shift_unit dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .bus_in     (bus_in),
    .a_in       (a_in),
    .op         (op),
    .shift_type (shift_type),
    .f_en       (f_en),
    .result     (result),
    .zero       (zero),
    .f_flag     (f_flag)
  );

  always #5 Clock = ~Clock;

  // Shift reference built from division/multiplication by powers of two.
  function automatic int ref_shift(input logic [1:0] st, input int ua, input int n);
    int sa;
    int p;
    sa = (ua >= 32768) ? ua - 65536 : ua;
    p  = 1 << n;
    case (st)
      2'd0:    return (ua * p) % 65536;
      2'd1:    return ua / p;
      2'd2:    return (sa >>> n) & 65535;
`ifdef ALU_SHIFT_ROR_EN
      default: return (ua / p) + (ua % p) * (65536 / p);
`else
      default: return ua;
`endif
    endcase
  endfunction

  function automatic logic [15:0] ref_alu(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [1:0] st);
    int ua;
    int ub;
    int r;
    ua = int'(a);
    ub = int'(b);
    case (o)
      3'd1:    r = (ua + ub) % 65536;
      3'd2:    r = (ua - ub + 65536) % 65536;
      3'd3:    r = int'(a & b);
      3'd4:    r = ref_shift(st, ua, ub % 16);
      default: r = ub;
    endcase
    return r[15:0];
  endfunction

  task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] st, input logic fe);
    op = o; a_in = a; bus_in = b; shift_type = st; f_en = fe;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    drive(3'd2, 16'h0005, 16'h0005, 2'd0, 1'b1);
    total++;
    if (f_flag !== 1'b0) begin
      bad++; $display("FAIL reset_initial: f_flag=%b required=0", f_flag);
    end
    tick(); tick();
    total++;
    if (f_flag !== 1'b0) begin
      bad++; $display("FAIL reset_hold_fen: f_flag=%b required=0", f_flag);
    end
    total++;
    if (result !== 16'h0000 || zero !== 1'b1) begin
      bad++; $display("FAIL reset_comb: result=%h zero=%b required=0000/1", result, zero);
    end
    #2 Resetn = 1'b1;
    tick();
    exp_flag = 1'b1;
    total++;
    if (f_flag !== 1'b1) begin
      bad++; $display("FAIL reset_first_load: f_flag=%b required=1", f_flag);
    end
  endtask

  task automatic test_boundary();
    logic [2:0]  t_op[13];
    logic [15:0] t_a[13];
    logic [15:0] t_b[13];
    logic [1:0]  t_st[13];
    logic [15:0] t_exp[13];
    logic [15:0] ror_exp;
`ifdef ALU_SHIFT_ROR_EN
    ror_exp = 16'h1800;
`else
    ror_exp = 16'h8001;
`endif
    t_op  = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6};
    t_a   = '{16'h7FFF, 16'hFFFF, 16'h0003, 16'h8001, 16'h8001, 16'h8001, 16'h8001,
              16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h1234};
    t_b   = '{16'h0001, 16'h0001, 16'h0005, 16'h0004, 16'h0004, 16'h0004, 16'h0004,
              16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFF4, 16'hBEEF};
    t_st  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    t_exp = '{16'h8000, 16'h0000, 16'hFFFE, 16'h0010, 16'h0800, 16'hF800, ror_exp,
              16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hF800, 16'hBEEF};
    for (int i = 0; i < 13; i++) begin
      drive(t_op[i], t_a[i], t_b[i], t_st[i], 1'b0);
      total++;
      if (result !== t_exp[i] || zero !== (t_exp[i] == 16'h0000)) begin
        bad++;
        $display("FAIL boundary[%0d]: result=%h zero=%b required=%h/%b",
                 i, result, zero, t_exp[i], (t_exp[i] == 16'h0000));
      end
    end
  endtask

  task automatic test_sub_flag();
    drive(3'd2, 16'h0005, 16'h0005, 2'd0, 1'b1);
    total++;
    if (result !== 16'h0000 || zero !== 1'b1) begin
      bad++; $display("FAIL sub_zero: result=%h zero=%b required=0000/1", result, zero);
    end
    tick();
    exp_flag = 1'b1;
    total++;
    if (f_flag !== 1'b1) begin
      bad++; $display("FAIL sub_flag_load: f_flag=%b required=1", f_flag);
    end
  endtask

  task automatic test_hold_and_async_reset();
    drive(3'd2, 16'h0005, 16'h0005, 2'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 16'h0000, 16'(1 + $urandom_range(0, 65534)), 2'd0, 1'b0);
      tick();
      total++;
      if (f_flag !== 1'b1) begin
        bad++; $display("FAIL flag_hold[%0d]: f_flag=%b required=1", i, f_flag);
      end
    end
    #2 Resetn = 1'b0;
    #1;
    exp_flag = 1'b0;
    total++;
    if (f_flag !== 1'b0) begin
      bad++; $display("FAIL async_reset: f_flag=%b required=0", f_flag);
    end
    #1 Resetn = 1'b1;
    drive(3'd3, 16'h00FF, 16'h00FF, 2'd0, 1'b1);
    tick();
    total++;
    if (f_flag !== 1'b0) begin
      bad++; $display("FAIL load_nonzero: f_flag=%b required=0", f_flag);
    end
  endtask

  task automatic test_shift_sweep();
    logic [15:0] a;
    logic [15:0] exp;
    for (int st = 0; st < 4; st++) begin
      for (int n = 0; n < 16; n++) begin
        a = 16'($urandom);
        drive(3'd4, a, {12'($urandom), 4'(n)}, 2'(st), 1'b0);
        exp = ref_alu(3'd4, a, 16'(n), 2'(st));
        total++;
        if (result !== exp) begin
          bad++;
          $display("FAIL shift st=%0d n=%0d a=%h: result=%h required=%h", st, n, a, result, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  o;
    logic [15:0] exp;
    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'h0000;
      drive(o, a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      exp = ref_alu(o, a, b, shift_type);
      total++;
      if (result !== exp || zero !== (exp == 16'h0000)) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h st=%0d: result=%h zero=%b required=%h/%b",
                 i, o, a, b, shift_type, result, zero, exp, (exp == 16'h0000));
      end
      if (f_en) exp_flag = (exp == 16'h0000);
      tick();
      total++;
      if (f_flag !== exp_flag) begin
        bad++; $display("FAIL random_flag[%0d]: f_flag=%b required=%b", i, f_flag, exp_flag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_sub_flag();
    test_hold_and_async_reset();
    test_shift_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
